debounce_scheduler: RTL and testbench
=====================================

DEBOUNCE_SCHEDULER -- requirements
Module: debounce_scheduler

Interface
REQ-001 Parameters SHALL be: N, default 4, number of button channels (2..8).
REQ-002 Parameters SHALL be: TICK_FLAG, default 999_999, terminal count of the shared sample timebase (10 ms at 100 MHz); legal values are TICK_FLAG >= N+2.
REQ-003 Parameters SHALL be: STABLE_CNT, default 4, number of consecutive disagreeing samples that flips a channel (1..15).
REQ-004 Ports SHALL be: clk  input  1  system clock, rising edge.
REQ-005 Ports SHALL be: reset  input  1  asynchronous, active-high reset.
REQ-006 Ports SHALL be: D_in  input  N  raw, bouncing button inputs.
REQ-007 Ports SHALL be: Q_out  output  N  debounced button levels.
REQ-008 Ports SHALL be: press  output  N  one-cycle pulse when Q_out[i] rises.
REQ-009 Ports SHALL be: release  output  N  one-cycle pulse when Q_out[i] falls.
REQ-010 Ports SHALL be: busy  output  1  high while the SCAN state is active.

Function
REQ-011 D_in SHALL pass through a 2-flop synchronizer per bit before use; the sampled value is d_s[i].
REQ-012 The timebase SHALL count 0..TICK_FLAG and then wrap; tick is high for exactly one cycle when count==TICK_FLAG.
REQ-013 The FSM SHALL have two states: IDLE and SCAN.
REQ-014 IDLE SHALL go to SCAN on tick, with scan index idx<=0; otherwise it stays in IDLE.
REQ-015 In SCAN, exactly one channel idx SHALL be serviced per clock; idx increments each cycle.
REQ-016 After servicing idx==N-1, the FSM SHALL return to IDLE; SCAN therefore lasts exactly N cycles.
REQ-017 Servicing channel i when d_s[i]==Q_out[i] SHALL clear cnt[i] to 0.
REQ-018 Servicing channel i when d_s[i]!=Q_out[i] and cnt[i]<STABLE_CNT-1 SHALL increment cnt[i].
REQ-019 Servicing channel i when d_s[i]!=Q_out[i] and cnt[i]==STABLE_CNT-1 SHALL toggle Q_out[i] and clear cnt[i].
REQ-020 When Q_out[i] toggles, press[i] (rising) or release[i] (falling) SHALL pulse in the same cycle the new Q_out[i] appears.
REQ-021 Press and release pulses SHALL never be asserted for two channels in the same cycle, since channels are serviced in distinct cycles.
REQ-022 A tick occurring while in SCAN SHALL be ignored; this is unreachable for legal TICK_FLAG values.
REQ-023 A channel whose input bounces back to match Q_out before reaching STABLE_CNT disagreeing samples SHALL restart from cnt=0 with no output change.
REQ-024 cnt[i] SHALL be exactly ceil(log2(STABLE_CNT+1)) bits wide and SHALL never exceed STABLE_CNT-1.
REQ-025 busy SHALL equal (state==SCAN), registered.
REQ-026 Latency SHALL be as follows: after d_s[i] becomes stable, Q_out[i] changes on the STABLE_CNT-th subsequent scan, i+1 cycles after that scan's tick.

Reset
REQ-027 On reset, the timebase count, idx, every cnt[i], and both synchronizer stages SHALL be cleared to 0, and the state SHALL be IDLE.
REQ-028 On reset, Q_out, press, release and busy SHALL be cleared to 0.
REQ-029 Reset asserted mid-SCAN SHALL abort the scan immediately and asynchronously; no pulse may be emitted in or after the reset cycle.
REQ-030 After reset is released, the first tick SHALL occur TICK_FLAG+1 clocks later.

Structure
REQ-031 The shared package SHALL hold the state encoding (IDLE=1'b0, SCAN=1'b1) and the default values of TICK_FLAG and STABLE_CNT.
REQ-032 The timebase SHALL be the existing pulse_generator sub-module, instantiated once with flag=TICK_FLAG; no per-channel timers are permitted.
REQ-033 Per-channel state SHALL be stored in arrays indexed by idx; exactly one compare/increment datapath SHALL be shared by all channels.

Verification (TICK_FLAG=9, N=4, STABLE_CNT=4 unless noted)
REQ-034 Reset only, 50 cycles: outputs all 0; busy high for 4 cycles out of every 10, starting 10 cycles after reset is released.
REQ-035 D_in=4'b0001 held: Q_out[0] rises on the 4th scan after synchronization; press[0] is high for exactly 1 cycle; release stays 0; other channels are unchanged.
REQ-036 D_in[2] toggling every 7 clocks for 100 clocks, then held 1: no output change during bouncing; press[2] occurs exactly once after 4 stable scans.
REQ-037 D_in 0000->1111 simultaneously: press[0..3] occur on 4 consecutive cycles of the same scan, one per cycle, in order 0,1,2,3.
REQ-038 Q_out=4'b1111, then D_in->0000: release pulses occur in order 0..3; Q_out returns to 0000; cnt values return to 0.
REQ-039 Reset asserted on the 2nd cycle of a SCAN in which press[3] would fire: press[3] never pulses; all state returns to 0; normal scanning resumes.

Source files
------------

// File: rtl/debounce_scheduler_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | debounce_scheduler_pkg : state encoding and parameter defaults   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package debounce_scheduler_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

  localparam int c_TICK_FLAG_DEFAULT  = 999_999;
  localparam int c_STABLE_CNT_DEFAULT = 4;

endpackage
`default_nettype wire

// File: rtl/pulse_generator.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pulse_generator : free-running 0..FLAG counter, one-cycle tick   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module pulse_generator #(
  parameter int FLAG = 9
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = (FLAG < 1) ? 1 : $clog2(FLAG + 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    tick    = (count_q == CW'(FLAG));
    count_d = tick ? '0 : count_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/debounce_scheduler.sv
`default_nettype none
// +------------------------------------------------------------------+
// | debounce_scheduler : N-channel debouncer, one shared datapath    |
// | serviced round-robin once per timebase tick. Rev 1.0             |
// +------------------------------------------------------------------+
module debounce_scheduler
  import debounce_scheduler_pkg::*;
#(
  parameter int N          = 4,
  parameter int TICK_FLAG  = c_TICK_FLAG_DEFAULT,
  parameter int STABLE_CNT = c_STABLE_CNT_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] D_in,
  output logic [N-1:0] Q_out,
  output logic [N-1:0] press,
  // "release" is a reserved word, hence the suffix
  output logic [N-1:0] release_pulse,
  output logic         busy
);

  localparam int CW    = $clog2(STABLE_CNT + 1);
  localparam int IDX_W = $clog2(N);

  logic                   tick;
  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [N-1:0][CW-1:0]   cnt_q, cnt_d;
  logic [N-1:0]           q_q, q_d;
  logic [N-1:0]           press_q, press_d;
  logic [N-1:0]           rel_q, rel_d;
  logic [N-1:0]           sync1_q, d_s_q;
  logic [CW-1:0]          cur_cnt;
  logic                   cur_d;
  logic                   cur_q;

  pulse_generator #(
    .FLAG (TICK_FLAG)
  ) u_timebase (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    press_d = '0;
    rel_d   = '0;
    cur_cnt = cnt_q[idx_q];
    cur_d   = d_s_q[idx_q];
    cur_q   = q_q[idx_q];

    case (state_q)
      IDLE: begin
        if (tick) begin
          state_d = SCAN;
          idx_d   = '0;
        end
      end
      SCAN: begin
        // Single shared compare/increment path, steered by idx
        if (cur_d == cur_q) begin
          cnt_d[idx_q] = '0;
        end else if (cur_cnt == CW'(STABLE_CNT - 1)) begin
          cnt_d[idx_q]   = '0;
          q_d[idx_q]     = cur_d;
          press_d[idx_q] = cur_d;
          rel_d[idx_q]   = ~cur_d;
        end else begin
          cnt_d[idx_q] = cur_cnt + 1'b1;
        end

        if (idx_q == IDX_W'(N - 1)) begin
          state_d = IDLE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      press_q <= '0;
      rel_q   <= '0;
      sync1_q <= '0;
      d_s_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      sync1_q <= D_in;
      d_s_q   <= sync1_q;
    end
  end

  assign Q_out         = q_q;
  assign press         = press_q;
  assign release_pulse = rel_q;
  assign busy          = (state_q == SCAN);

endmodule
`default_nettype wire

// File: tb/tb_debounce_scheduler.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_debounce_scheduler : directed self-checking bench             |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_debounce_scheduler;

  logic       clk;
  logic       rst;
  logic [3:0] d_in;
  logic [3:0] q_out;
  logic [3:0] press;
  logic [3:0] rel;
  logic       busy;

  int n_checks;
  int n_errors;
  int cyc;
  int press_cnt [4];
  int rel_cnt   [4];

  debounce_scheduler #(
    .N          (4),
    .TICK_FLAG  (9),
    .STABLE_CNT (4)
  ) dut (
    .clk           (clk),
    .reset         (rst),
    .D_in          (d_in),
    .Q_out         (q_out),
    .press         (press),
    .release_pulse (rel),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    for (int i = 0; i < 4; i++) begin
      press_cnt[i] = 0;
      rel_cnt[i]   = 0;
    end
  endtask

  // Advance one clock; sample 1 time unit after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < 4; i++) begin
      if (press[i]) press_cnt[i]++;
      if (rel[i])   rel_cnt[i]++;
    end
  endtask

  task automatic run_to(input int c);
    while (cyc < c) step();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    cyc      = 0;
    rst      = 1'b1;
    d_in     = 4'b0000;
    clear_mon();
    repeat (3) step();
    chk("rst_q_out", 32'(q_out), 32'h0);
    chk("rst_press", 32'(press), 32'h0);
    chk("rst_release", 32'(rel), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    cyc = 0;

    // Idle timebase: busy is SCAN for cycles 10..13, 20..23, ...
    for (int c = 1; c <= 50; c++) begin
      step();
      chk("idle_busy", 32'(busy), 32'((c >= 10) && ((c % 10) < 4)));
    end
    chk("idle_outs", {20'h0, q_out, press, rel}, 32'h0);

    // Single press on channel 0: toggles on the 4th scan, at cycle 91
    d_in = 4'b0001;
    clear_mon();
    run_to(90);
    chk("p0_before", 32'(q_out), 32'h0);
    run_to(91);
    chk("p0_q_out", 32'(q_out), 32'h1);
    chk("p0_press", 32'(press), 32'h1);
    chk("p0_release", 32'(rel), 32'h0);
    run_to(100);
    chk("p0_press_cnt", 32'(press_cnt[0]), 32'd1);
    chk("p0_rel_none", 32'(rel_cnt[0] + rel_cnt[1] + rel_cnt[2] + rel_cnt[3]), 32'd0);
    chk("p0_others", 32'(q_out), 32'h1);

    // Channel 2 bounces every 7 clocks, then held high from cycle 200
    clear_mon();
    while (cyc < 200) begin
      d_in[2] = 1'(((cyc - 100) / 7) % 2);
      step();
    end
    d_in[2] = 1'b1;
    run_to(232);
    chk("b2_no_change", 32'(q_out), 32'h1);
    chk("b2_no_press", 32'(press_cnt[2]), 32'd0);
    run_to(233);
    chk("b2_q_out", 32'(q_out), 32'h5);
    chk("b2_press", 32'(press), 32'h4);
    run_to(240);
    chk("b2_press_cnt", 32'(press_cnt[2]), 32'd1);
    chk("b2_rel_none", 32'(rel_cnt[0] + rel_cnt[1] + rel_cnt[2] + rel_cnt[3]), 32'd0);

    // Reset, then all four channels pressed together
    rst = 1'b1;
    #1;
    chk("rst2_q_out", 32'(q_out), 32'h0);
    repeat (3) step();
    rst  = 1'b0;
    cyc  = 0;
    d_in = 4'b1111;
    clear_mon();
    run_to(40);
    chk("all_before", {24'h0, q_out, press}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("all_press_order", 32'(press), 32'(1 << i));
    end
    chk("all_q_out", 32'(q_out), 32'hF);

    // All four released: release pulses at cycles 81..84 in channel order
    run_to(45);
    d_in = 4'b0000;
    clear_mon();
    run_to(80);
    chk("rel_before", {24'h0, q_out, rel}, 32'hF0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rel_order", 32'(rel), 32'(1 << i));
    end
    chk("rel_q_out", 32'(q_out), 32'h0);
    run_to(85);
    chk("rel_total", 32'(rel_cnt[0] + rel_cnt[1] + rel_cnt[2] + rel_cnt[3]), 32'd4);
    chk("rel_no_press", 32'(press_cnt[0] + press_cnt[1] + press_cnt[2] + press_cnt[3]), 32'd0);

    // Channel 3 would press at cycle 124; reset lands at cycle 121
    d_in = 4'b1000;
    clear_mon();
    run_to(121);
    chk("abort_busy", 32'(busy), 32'h1);
    chk("abort_q_pre", 32'(q_out), 32'h0);
    rst = 1'b1;
    #1;
    chk("abort_outs", {19'h0, busy, q_out, press, rel}, 32'h0);
    repeat (3) step();
    chk("abort_no_press", 32'(press_cnt[3]), 32'd0);
    rst = 1'b0;
    cyc = 0;
    clear_mon();
    run_to(9);
    chk("resume_busy_lo", 32'(busy), 32'h0);
    run_to(10);
    chk("resume_busy_hi", 32'(busy), 32'h1);
    run_to(43);
    chk("resume_pre", {24'h0, q_out, press}, 32'h0);
    run_to(44);
    chk("resume_press", 32'(press), 32'h8);
    chk("resume_q_out", 32'(q_out), 32'h8);
    run_to(50);
    chk("resume_press_cnt", 32'(press_cnt[3]), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
